mc_datapath: RTL
================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width in bits (>=16).
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-003 SHALL have parameter MAX_WAIT, default 255, memory-wait cycles before bus error.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- RegSrc  in  2  register-address select, same meaning as single-cycle datapath.
- ImmSrc  in  2  extend mode.
- ALUSrc  in  1  SrcB select.
- ALUControl  in  2  00 add, 01 sub, 10 and, 11 orr.
- MemtoReg  in  1  writeback select.
- MemOp  in  1  instruction is load/store.
- MemWrite  in  1  store when MemOp=1.
- RegWrite  in  1  register write request.
- PCSrc  in  1  writeback targets PC.
- FlagWrite  in  1  update flag register.
- CondEx  in  1  condition passed.
- Instr  out  32  instruction register.
- Flags  out  4  registered NZCV.
- PC  out  WIDTH  program counter.
- mem_req  out  1  bus request.
- mem_we  out  1  write strobe.
- mem_addr  out  WIDTH  bus address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  load/fetch data.
- mem_ready  in  1  transfer complete this cycle.
- retire  out  1  one-cycle pulse per completed instruction.
- bus_err  out  1  sticky timeout error.

Function
REQ-005 SHALL sequence FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK -> FETCH; ERROR is terminal until reset.
REQ-006 FETCH SHALL hold mem_req=1, mem_we=0, mem_addr=PC; on mem_ready SHALL latch Instr=mem_rdata[31:0], set PC=PC+4 and go to DECODE.
REQ-007 DECODE SHALL latch A=reg[RA1] and B=reg[RA2] with RegSrc muxing as in the single-cycle design; a read of R15 SHALL return PC+4 (instruction address + 8).
REQ-008 DECODE SHALL latch ExtImm: 00 zero-extended Instr[7:0]; 01 zero-extended Instr[11:0]; 10 sign-extended {Instr[23:0],2'b00}; 11 zero.
REQ-009 EXECUTE SHALL latch ALUOut=ALU(A, ALUSrc?ExtImm:B); if FlagWrite&CondEx SHALL latch Flags; next state MEMORY if MemOp&CondEx, else WRITEBACK.
REQ-010 ALU flags SHALL be N=msb, Z=all-zero, C=carry-out (add/sub, sub carry=no borrow), V=signed overflow (add/sub); C,V=0 for and/orr; arithmetic modulo 2^WIDTH.
REQ-011 MEMORY SHALL hold mem_req=1, mem_addr=ALUOut, mem_we=MemWrite, mem_wdata=B, all stable until mem_ready; load SHALL latch Data=mem_rdata.
REQ-012 WRITEBACK SHALL form Result=MemtoReg?Data:ALUOut; if CondEx&RegWrite&!PCSrc write reg[Instr[15:12]]; if CondEx&PCSrc set PC=Result; then pulse retire and go to FETCH.
REQ-013 CondEx=0 SHALL suppress register, PC, flag and memory effects; instruction still retires.
REQ-014 mem_req SHALL be 0 outside FETCH/MEMORY; no new request SHALL issue in the cycle mem_ready is seen.
REQ-015 Wait counter SHALL count cycles with mem_req=1 and mem_ready=0; reaching MAX_WAIT SHALL enter ERROR, set bus_err=1, drop mem_req.
REQ-016 Register-file writes SHALL occur only in WRITEBACK; simultaneous read/write of one register cannot occur by construction.

Reset
REQ-017 reset low SHALL immediately force state FETCH, PC=RESET_PC, Instr=0, Flags=0, A/B/ALUOut/Data=0, wait counter=0, retire=0, bus_err=0; register contents unspecified.
REQ-018 Reset asserted mid-transfer SHALL drop mem_req in the same cycle; first request after release SHALL be fetch at RESET_PC.

Structure
REQ-019 Shared package SHALL hold state enum, ALUControl and ImmSrc encodings, and the R15 index constant.
REQ-020 ALU SHALL be a sub-module named alu_p, parametrised by WIDTH; register file, extend and muxes stay inline.

Verification
REQ-021 ADD R1,R0,#5 (R0=3), ready zero-wait -> R1=8, retire after 4 cycles, Flags unchanged when FlagWrite=0.
REQ-022 SUBS R2,R1,R1 with FlagWrite=1 -> R2=0, Flags=0110 (Z=1,C=1).
REQ-023 STR then LDR at address 0x40 with 3-cycle ready delay -> mem_addr/we/wdata stable 3 cycles, loaded value matches, retire after 5 states.
REQ-024 Branch (PCSrc=1, Result=0x100) -> next fetch mem_addr=0x100; CondEx=0 variant -> next fetch at PC+4.
REQ-025 mem_ready held low MAX_WAIT cycles -> bus_err=1, mem_req=0, stays until reset.
REQ-026 reset asserted during MEMORY wait -> mem_req=0 immediately, PC=RESET_PC, fetch restarts after release.

Source files
------------

// File: rtl/mc_datapath_pkg.sv
// Shared encodings for the multicycle datapath: FSM states, ALU and
// extend selectors, and the PC-aliased register index.
package mc_datapath_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_B8   = 2'b00,
        IMM_B12  = 2'b01,
        IMM_BR24 = 2'b10,
        IMM_ZERO = 2'b11
    } imm_src_t;

    localparam logic [3:0] R15 = 4'd15;

endpackage

// File: rtl/alu_p.sv
// Add/sub/and/orr ALU with NZCV flags; sub is a + ~b + 1 so C means
// no borrow.
module alu_p
    import mc_datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       nzcv
);

    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic             c;
    logic             v;

    always_comb begin
        sub = (op == ALU_SUB);
        bx  = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op)
            ALU_ADD, ALU_SUB: begin
                y = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == bx[WIDTH-1]) &&
                    (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: y = a & b;
            ALU_ORR: y = a | b;
        endcase
        nzcv = {y[WIDTH-1], y == '0, c, v};
    end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle ARM-subset datapath sharing one memory port between fetch
// and data, with a watchdog that parks the core in ERROR on a stall.
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       RegSrc,
    input  logic [1:0]       ImmSrc,
    input  logic             ALUSrc,
    input  logic [1:0]       ALUControl,
    input  logic             MemtoReg,
    input  logic             MemOp,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             PCSrc,
    input  logic             FlagWrite,
    input  logic             CondEx,
    output logic [31:0]      Instr,
    output logic [3:0]       Flags,
    output logic [WIDTH-1:0] PC,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             retire,
    output logic             bus_err
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] rf [16];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] ext_q;
    logic [WIDTH-1:0] alu_q;
    logic [WIDTH-1:0] data_q;
    logic [WW-1:0]    wait_cnt;

    logic [3:0]       ra1;
    logic [3:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] ext;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] alu_y;
    logic [3:0]       alu_nzcv;
    logic             busy;
    logic             timeout;
    logic             rf_we;

    alu_p #(.WIDTH(WIDTH)) u_alu (
        .a    (a_q),
        .b    (src_b),
        .op   (alu_op_t'(ALUControl)),
        .y    (alu_y),
        .nzcv (alu_nzcv)
    );

    // R15 reads see the instruction address + 8; PC already holds +4 here.
    always_comb begin
        pc_plus4 = PC + WIDTH'(4);
        ra1      = RegSrc[0] ? R15 : Instr[19:16];
        ra2      = RegSrc[1] ? Instr[15:12] : Instr[3:0];
        rd1      = (ra1 == R15) ? pc_plus4 : rf[ra1];
        rd2      = (ra2 == R15) ? pc_plus4 : rf[ra2];
        unique case (imm_src_t'(ImmSrc))
            IMM_B8:   ext = WIDTH'(Instr[7:0]);
            IMM_B12:  ext = WIDTH'(Instr[11:0]);
            IMM_BR24: ext = WIDTH'(signed'({Instr[23:0], 2'b00}));
            IMM_ZERO: ext = '0;
        endcase
        src_b  = ALUSrc ? ext_q : b_q;
        result = MemtoReg ? data_q : alu_q;
    end

    // Reset gates the bus directly so a transfer drops in the same cycle.
    always_comb begin
        busy      = reset && ((state == S_FETCH) || (state == S_MEM));
        mem_req   = busy;
        mem_we    = reset && (state == S_MEM) && MemWrite;
        mem_addr  = (state == S_MEM) ? alu_q : PC;
        mem_wdata = b_q;
        retire    = (state == S_WB);
        timeout   = busy && !mem_ready &&
                    (wait_cnt == WW'(MAX_WAIT - 1));
        rf_we     = (state == S_WB) && CondEx && RegWrite &&
                    !PCSrc && (Instr[15:12] != R15);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_FETCH: begin
                if (timeout)        state_n = S_ERROR;
                else if (mem_ready) state_n = S_DECODE;
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC:   state_n = (MemOp && CondEx) ? S_MEM : S_WB;
            S_MEM: begin
                if (timeout)        state_n = S_ERROR;
                else if (mem_ready) state_n = S_WB;
            end
            S_WB:     state_n = S_FETCH;
            S_ERROR:  state_n = S_ERROR;
            default:  state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            PC       <= RESET_PC;
            Instr    <= '0;
            Flags    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ext_q    <= '0;
            alu_q    <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        Instr <= 32'(mem_rdata);
                        PC    <= pc_plus4;
                    end
                end
                S_DECODE: begin
                    a_q   <= rd1;
                    b_q   <= rd2;
                    ext_q <= ext;
                end
                S_EXEC: begin
                    alu_q <= alu_y;
                    if (FlagWrite && CondEx) Flags <= alu_nzcv;
                end
                S_MEM: begin
                    if (mem_ready && !MemWrite) data_q <= mem_rdata;
                end
                S_WB: begin
                    if (CondEx && PCSrc) PC <= result;
                end
                default: ;
            endcase
            if (busy && !mem_ready) wait_cnt <= wait_cnt + WW'(1);
            else                    wait_cnt <= '0;
            if (timeout) bus_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf[Instr[15:12]] <= result;
    end

endmodule
